// File: rtl/motor_drv_pkg.sv
// Shared definitions for the N-phase half-bridge gate driver.
// Holds the per-phase command encoding, the phase FSM state type and the
// default dead-time length used by the driver and its per-phase sub-module.
package motor_drv_pkg;

    // Per-phase command encoding on down1_up2i
    localparam logic [1:0] CMD_OFF  = 2'd0;
    localparam logic [1:0] CMD_DOWN = 2'd1;
    localparam logic [1:0] CMD_UP   = 2'd2;
    localparam logic [1:0] CMD_ILL  = 2'd3;

    // Default number of both-off cycles after a side turns off
    localparam int unsigned DEAD_CYC_DEFAULT = 8;
    localparam int unsigned DW_DEFAULT       = 8;

    // Phase states: IDLE (both off), HIGH (high side on), LOW (low side on),
    // DEAD (both off, counting out the dead time)
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2,
        StDead = 2'd3
    } phase_state_e;

endpackage

// File: rtl/motor_halfbridge_deadtime_phase.sv
// One half-bridge leg: phase FSM, dead-time counter and registered gate outputs.
// Ports:
//   clk        in   1   clock
//   rst        in   1   synchronous reset, active-high
//   cmd        in   2   0=off 1=down 2=up 3=illegal (treated as off)
//   force_dead in   1   fault active: park in DEAD with the counter reloaded
//   hin        out  1   high-side gate, 1=on
//   nlin       out  1   low-side gate, 0=on
//   dead       out  1   1 while in dead time
module motor_halfbridge_deadtime_phase
    import motor_drv_pkg::*;
#(
    parameter int unsigned DEAD_CYC = DEAD_CYC_DEFAULT,
    parameter int unsigned DW       = DW_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cmd,
    input  logic       force_dead,
    output logic       hin,
    output logic       nlin,
    output logic       dead
);

    // Counter starts at DEAD_CYC-1 and leaves DEAD on the edge after it hits 0,
    // giving exactly DEAD_CYC both-off cycles.
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYC - 1);

    phase_state_e    state_q, state_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic            hin_q, nlin_q, dead_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (force_dead) begin
            state_d = StDead;
            cnt_d   = DEAD_LOAD;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd == CMD_UP) begin
                        state_d = StHigh;
                    end else if (cmd == CMD_DOWN) begin
                        state_d = StLow;
                    end
                end
                StHigh: begin
                    if (cmd != CMD_UP) begin
                        state_d = StDead;
                        cnt_d   = DEAD_LOAD;
                    end
                end
                StLow: begin
                    if (cmd != CMD_DOWN) begin
                        state_d = StDead;
                        cnt_d   = DEAD_LOAD;
                    end
                end
                StDead: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (cmd == CMD_UP) begin
                        state_d = StHigh;
                    end else if (cmd == CMD_DOWN) begin
                        state_d = StLow;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Gate outputs are decoded from the next state so they are glitch-free
    // registers with one clock of command latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hin_q   <= 1'b0;
            nlin_q  <= 1'b1;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hin_q   <= (state_d == StHigh);
            nlin_q  <= (state_d != StLow);
            dead_q  <= (state_d == StDead);
        end
    end

    assign hin  = hin_q;
    assign nlin = nlin_q;
    assign dead = dead_q;

endmodule

// File: rtl/motorn_halfbridge_deadtime_driver.sv
// N-phase half-bridge gate driver with dead-time insertion and latched fault
// shutdown, for IRS2007S-class gate drivers.
// Ports:
//   clkI        in   1      clock
//   rstI        in   1      synchronous reset, active-high
//   down1_up2i  in   2*NPH  per-phase cmd, bits[2p+1:2p]: 0=off 1=down 2=up 3=illegal
//   fltI        in   1      external fault, active-high
//   fltClrI     in   1      fault-latch clear request (level)
//   HinO        out  NPH    high-side gates, 1=on
//   nLinO       out  NPH    low-side gates, 0=on
//   deadO       out  NPH    1 while the phase is in dead time
//   fltLatchO   out  1      1 while the fault is latched
//   illegalO    out  1      sticky flag: a cmd==3 was seen (cleared by reset only)
module motorn_halfbridge_deadtime_driver
    import motor_drv_pkg::*;
#(
    parameter int unsigned NPH      = 3,
    parameter int unsigned DEAD_CYC = DEAD_CYC_DEFAULT,
    parameter int unsigned DW       = DW_DEFAULT
) (
    input  logic             clkI,
    input  logic             rstI,
    input  logic [2*NPH-1:0] down1_up2i,
    input  logic             fltI,
    input  logic             fltClrI,
    output logic [NPH-1:0]   HinO,
    output logic [NPH-1:0]   nLinO,
    output logic [NPH-1:0]   deadO,
    output logic             fltLatchO,
    output logic             illegalO
);

    logic flt_latch_q, flt_latch_d;
    logic illegal_q, illegal_d;
    logic force_dead;
    logic any_ill;

    // A fault parks the phases on the same edge it is sampled and keeps them
    // parked while latched; the edge that clears the latch still reloads the
    // counters, so every phase counts a full dead time after the clear.
    assign force_dead  = fltI | flt_latch_q;
    assign flt_latch_d = fltI | (flt_latch_q & ~fltClrI);

    always_comb begin
        any_ill = 1'b0;
        for (int p = 0; p < int'(NPH); p++) begin
            if (down1_up2i[2*p +: 2] == CMD_ILL) begin
                any_ill = 1'b1;
            end
        end
    end

    assign illegal_d = illegal_q | any_ill;

    always_ff @(posedge clkI) begin
        if (rstI) begin
            flt_latch_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            flt_latch_q <= flt_latch_d;
            illegal_q   <= illegal_d;
        end
    end

    for (genvar p = 0; p < int'(NPH); p++) begin : g_phase
        motor_halfbridge_deadtime_phase #(
            .DEAD_CYC (DEAD_CYC),
            .DW       (DW)
        ) u_phase (
            .clk        (clkI),
            .rst        (rstI),
            .cmd        (down1_up2i[2*p +: 2]),
            .force_dead (force_dead),
            .hin        (HinO[p]),
            .nlin       (nLinO[p]),
            .dead       (deadO[p])
        );
    end

    assign fltLatchO = flt_latch_q;
    assign illegalO  = illegal_q;

endmodule
